// File: rtl/reg_file_sb.sv
// Register file with write-through bypass and a per-register pending scoreboard.
// Tracks outstanding producers so readers can detect RAW hazards.
module reg_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_register,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              busy_1,
  output logic              busy_2,
  output logic              hazard,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wr_en, iss_en, cnt_inc, cnt_dec;
  logic zero_rd_1, zero_rd_2;

  assign wr_en     = reg_write   && !(ZERO_REG && (write_register == '0));
  assign iss_en    = issue_valid && !(ZERO_REG && (issue_dst == '0));
  assign zero_rd_1 = ZERO_REG && (read_reg_1 == '0);
  assign zero_rd_2 = ZERO_REG && (read_reg_2 == '0);

  // Set wins over clear so a newly issued producer is never lost.
  always_comb begin
    pend_d = pend_q;
    if (reg_write) pend_d[write_register] = 1'b0;
    if (iss_en)    pend_d[issue_dst]      = 1'b1;
  end

  assign cnt_inc = iss_en && !pend_q[issue_dst];
  assign cnt_dec = reg_write && pend_q[write_register] &&
                   !(iss_en && (issue_dst == write_register));

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && !cnt_dec)      cnt_d = cnt_q + CntOne;
    else if (cnt_dec && !cnt_inc) cnt_d = cnt_q - CntOne;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) regs_q[write_register] <= write_data;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    read_data_1 = regs_q[read_reg_1];
    if (wr_en && (write_register == read_reg_1)) read_data_1 = write_data;
    if (zero_rd_1) read_data_1 = '0;

    read_data_2 = regs_q[read_reg_2];
    if (wr_en && (write_register == read_reg_2)) read_data_2 = write_data;
    if (zero_rd_2) read_data_2 = '0;
  end

  // A writeback landing this cycle resolves the hazard for its register.
  assign busy_1 = pend_q[read_reg_1] && !(reg_write && (write_register == read_reg_1)) &&
                  !zero_rd_1;
  assign busy_2 = pend_q[read_reg_2] && !(reg_write && (write_register == read_reg_2)) &&
                  !zero_rd_2;
  assign hazard   = busy_1 || busy_2;
  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_reg_file_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reg_write = 1'b0;
  logic [AW-1:0] write_register = '0;
  logic [DW-1:0] write_data = '0;
  logic [AW-1:0] read_reg_1 = '0;
  logic [AW-1:0] read_reg_2 = '0;
  logic [DW-1:0] read_data_1, read_data_2;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_dst = '0;
  logic          busy_1, busy_2, hazard;
  logic [AW:0]   pend_cnt;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .read_reg_1     (read_reg_1),
    .read_reg_2     (read_reg_2),
    .read_data_1    (read_data_1),
    .read_data_2    (read_data_2),
    .issue_valid    (issue_valid),
    .issue_dst      (issue_dst),
    .busy_1         (busy_1),
    .busy_2         (busy_2),
    .hazard         (hazard),
    .pend_cnt       (pend_cnt)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference model: register contents and set of pending registers.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_pend[i];
    return n;
  endfunction

  function automatic logic [DW-1:0] m_read(input int a);
    if (a == 0) return '0;
    if (reg_write && int'(write_register) == a) return write_data;
    return m_mem[a];
  endfunction

  function automatic logic m_busy(input int a);
    if (a == 0) return 1'b0;
    return m_pend[a] && !(reg_write && int'(write_register) == a);
  endfunction

  task automatic drive(input logic rw, input int wr, input logic [DW-1:0] wd,
                       input logic iv, input int dst, input int r1, input int r2);
    reg_write      = rw;
    write_register = AW'(wr);
    write_data     = wd;
    issue_valid    = iv;
    issue_dst      = AW'(dst);
    read_reg_1     = AW'(r1);
    read_reg_2     = AW'(r2);
  endtask

  // Advance one edge, applying the architectural rules to the model, then settle.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (reg_write && write_register != 0) m_mem[write_register] = write_data;
      if (reg_write) m_pend[write_register] = 1'b0;
      if (issue_valid && issue_dst != 0) m_pend[issue_dst] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1'b1, 5, 32'h55AA_55AA, 1'b1, 5, 5, 6);
    tick();
    tick();
    drive(1'b0, 0, '0, 1'b0, 0, 5, 6);
    #1;
    vecs++;
    if (pend_cnt !== 0) begin
      errs++; $display("FAIL reset_pend_cnt: got %0d want 0", pend_cnt);
    end
    vecs++;
    if (read_data_1 !== 0 || busy_1 !== 0 || busy_2 !== 0 || hazard !== 0) begin
      errs++;
      $display("FAIL reset_state: rd1=%h b1=%b b2=%b hz=%b want 0 0 0 0",
               read_data_1, busy_1, busy_2, hazard);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    drive(1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 0, 0);
    tick();
    drive(1'b0, 0, '0, 1'b0, 0, 5, 5);
    #1;
    vecs++;
    if (read_data_1 !== 32'hDEAD_BEEF || read_data_2 !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL write_read_r5: got %h/%h want deadbeef/deadbeef", read_data_1, read_data_2);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 7, 32'h0000_1234, 1'b0, 0, 7, 5);
    #1;
    vecs++;
    if (read_data_1 !== 32'h0000_1234) begin
      errs++; $display("FAIL bypass_r7: got %h want 00001234", read_data_1);
    end
    vecs++;
    if (read_data_2 !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL bypass_other_port: got %h want deadbeef", read_data_2);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 0, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
    #1;
    vecs++;
    if (read_data_1 !== 0 || busy_1 !== 0) begin
      errs++; $display("FAIL zero_bypass: rd1=%h b1=%b want 0 0", read_data_1, busy_1);
    end
    tick();
    drive(1'b0, 0, '0, 1'b0, 0, 0, 0);
    #1;
    vecs++;
    if (read_data_1 !== 0 || busy_1 !== 0 || pend_cnt !== 0) begin
      errs++;
      $display("FAIL zero_after: rd1=%h b1=%b cnt=%0d want 0 0 0", read_data_1, busy_1, pend_cnt);
    end
  endtask

  task automatic test_hazard();
    drive(1'b0, 0, '0, 1'b1, 3, 0, 0);
    tick();
    drive(1'b0, 0, '0, 1'b0, 0, 3, 0);
    #1;
    vecs++;
    if (busy_1 !== 1 || hazard !== 1 || pend_cnt !== 1) begin
      errs++;
      $display("FAIL hazard_set: b1=%b hz=%b cnt=%0d want 1 1 1", busy_1, hazard, pend_cnt);
    end
    drive(1'b1, 3, 32'h0000_0333, 1'b0, 0, 3, 0);
    #1;
    vecs++;
    if (busy_1 !== 0 || hazard !== 0) begin
      errs++; $display("FAIL hazard_wb_resolve: b1=%b hz=%b want 0 0", busy_1, hazard);
    end
    tick();
    drive(1'b0, 0, '0, 1'b0, 0, 3, 0);
    #1;
    vecs++;
    if (pend_cnt !== 0 || read_data_1 !== 32'h0000_0333) begin
      errs++;
      $display("FAIL hazard_cleared: cnt=%0d rd1=%h want 0 00000333", pend_cnt, read_data_1);
    end
  endtask

  task automatic test_set_priority();
    drive(1'b0, 0, '0, 1'b1, 4, 0, 0);
    tick();
    drive(1'b1, 4, 32'h0000_0444, 1'b1, 4, 4, 0);
    #1;
    vecs++;
    if (busy_1 !== 0) begin
      errs++; $display("FAIL prio_same_cycle_busy: got %b want 0", busy_1);
    end
    tick();
    drive(1'b0, 0, '0, 1'b0, 0, 4, 0);
    #1;
    vecs++;
    if (busy_1 !== 1 || pend_cnt !== 1) begin
      errs++; $display("FAIL prio_stays_set: b1=%b cnt=%0d want 1 1", busy_1, pend_cnt);
    end
    drive(1'b1, 4, 32'h0000_0445, 1'b0, 0, 4, 0);
    tick();
    drive(1'b0, 0, '0, 1'b0, 0, 4, 0);
    #1;
    vecs++;
    if (busy_1 !== 0 || pend_cnt !== 0) begin
      errs++; $display("FAIL prio_final_clear: b1=%b cnt=%0d want 0 0", busy_1, pend_cnt);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, i, 32'hA000_0000 + i, 1'b0, 0, 0, 0);
      tick();
    end
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 0, '0, 1'b1, i, 0, 0);
      tick();
    end
    drive(1'b0, 0, '0, 1'b0, 0, 1, 2);
    #1;
    vecs++;
    if (pend_cnt !== 3 || busy_1 !== 1 || busy_2 !== 1) begin
      errs++;
      $display("FAIL mid_before_reset: cnt=%0d b1=%b b2=%b want 3 1 1", pend_cnt, busy_1, busy_2);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vecs++;
    if (pend_cnt !== 0 || busy_1 !== 0 || busy_2 !== 0 || hazard !== 0) begin
      errs++;
      $display("FAIL mid_reset_sb: cnt=%0d b1=%b b2=%b hz=%b want 0 0 0 0",
               pend_cnt, busy_1, busy_2, hazard);
    end
    vecs++;
    if (read_data_1 !== 0 || read_data_2 !== 0) begin
      errs++; $display("FAIL mid_reset_r1r2: got %h/%h want 0/0", read_data_1, read_data_2);
    end
    read_reg_1 = 3;
    #1;
    vecs++;
    if (read_data_1 !== 0) begin
      errs++; $display("FAIL mid_reset_r3: got %h want 0", read_data_1);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int r1, r2;
    logic [DW-1:0] e1, e2;
    logic eb1, eb2;
    for (int n = 0; n < 500; n++) begin
      // Narrow address range on most cycles to provoke collisions.
      int hi = ($urandom_range(0, 3) == 0) ? DEPTH - 1 : 7;
      drive(1'($urandom_range(0, 1)), $urandom_range(0, hi), $urandom(),
            1'($urandom_range(0, 1)), $urandom_range(0, hi),
            $urandom_range(0, hi), $urandom_range(0, hi));
      #1;
      r1 = read_reg_1;
      r2 = read_reg_2;
      e1 = m_read(r1);
      e2 = m_read(r2);
      eb1 = m_busy(r1);
      eb2 = m_busy(r2);
      vecs++;
      if (read_data_1 !== e1) begin
        errs++; $display("FAIL rand_rd1[%0d] r%0d: got %h want %h", n, r1, read_data_1, e1);
      end
      vecs++;
      if (read_data_2 !== e2) begin
        errs++; $display("FAIL rand_rd2[%0d] r%0d: got %h want %h", n, r2, read_data_2, e2);
      end
      vecs++;
      if (busy_1 !== eb1 || busy_2 !== eb2 || hazard !== (eb1 | eb2)) begin
        errs++;
        $display("FAIL rand_busy[%0d]: got %b%b%b want %b%b%b", n,
                 busy_1, busy_2, hazard, eb1, eb2, eb1 | eb2);
      end
      vecs++;
      if (int'(pend_cnt) != m_cnt()) begin
        errs++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, pend_cnt, m_cnt());
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_hazard();
    test_set_priority();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
